// File: rtl/hier_pipe_chain_if.sv
// Handshake bundle for hier_pipe_chain: upstream beat (head operand plus
// per-stage side operands), downstream result and the delivery counter.
interface hier_pipe_chain_if #(
    parameter int WIDTH  = 2,
    parameter int STAGES = 2
);
    logic                      in_valid;
    logic                      in_ready;
    logic [WIDTH-1:0]          in_a;
    logic [STAGES*WIDTH-1:0]   in_b;
    logic                      out_valid;
    logic                      out_ready;
    logic [WIDTH-1:0]          out_data;
    logic [15:0]               beat_count;

    // Producer/consumer side of the chain (drives beats, accepts results).
    modport master (
        output in_valid, in_a, in_b, out_ready,
        input  in_ready, out_valid, out_data, beat_count
    );

    // The chain itself.
    modport slave (
        input  in_valid, in_a, in_b, out_ready,
        output in_ready, out_valid, out_data, beat_count
    );
endinterface

// File: rtl/hier_pipe_chain.sv
// hier_pipe_chain: STAGES chained combine stages with valid/ready flow
// control. Stage 0 folds in_a with side slice 0; each later stage folds the
// previous partial result with its own side slice. Side slices not yet
// consumed travel with the beat, so in_b is only sampled when a beat is
// accepted. Each stage loads whenever it is empty or its content moves on in
// the same cycle, giving full throughput and bubble collapse under
// backpressure.
module hier_pipe_chain #(
    parameter int WIDTH  = 2,
    parameter int STAGES = 2,
    parameter int MODE   = 0
) (
    input  logic               clk,
    input  logic               reset,
    hier_pipe_chain_if.slave   bus
);
    localparam int SB_W = STAGES * WIDTH;

    // Combine operator selected by MODE; ADD keeps only WIDTH bits so the
    // carry out of the top bit is dropped.
    function automatic logic [WIDTH-1:0] f_combine(input logic [WIDTH-1:0] op_a,
                                                   input logic [WIDTH-1:0] op_b);
        logic [WIDTH-1:0] res;
        res = '0;
        case (MODE)
            0:       res = op_a ^ op_b;
            1:       res = op_a & op_b;
            2:       res = op_a | op_b;
            default: res = op_a + op_b;
        endcase
        return res;
    endfunction

    // Per-stage state exported for the neighbouring stage and the outputs.
    logic [STAGES-1:0] w_valid;
    logic [WIDTH-1:0]  w_data [STAGES];

    genvar gi;
    generate
        for (gi = 0; gi < STAGES; gi++) begin : g_stage
            // Side operands still owed to stages gi+1 .. STAGES-1.
            localparam int SIDE_W = (STAGES - 1 - gi) * WIDTH;

            logic             r_valid;
            logic [WIDTH-1:0] r_data;
            logic             w_ready;
            logic             w_down_ready;
            logic             w_src_valid;
            logic [WIDTH-1:0] w_src_a;
            logic [WIDTH-1:0] w_src_b;
            logic             w_load;

            // Where this stage's operands come from.
            if (gi == 0) begin : g_head
                assign w_src_valid = bus.in_valid;
                assign w_src_a     = bus.in_a;
                assign w_src_b     = bus.in_b[WIDTH-1:0];
            end else begin : g_link
                assign w_src_valid = w_valid[gi-1];
                assign w_src_a     = w_data[gi-1];
                assign w_src_b     = g_stage[gi-1].g_side.r_side[WIDTH-1:0];
            end

            // Whether the content of this stage can move on this cycle.
            if (gi == STAGES - 1) begin : g_tail
                assign w_down_ready = bus.out_ready;
            end else begin : g_mid
                assign w_down_ready = g_stage[gi+1].w_ready;
            end

            // Stage can take new content when empty or when it is emptying.
            assign w_ready = !r_valid || w_down_ready;
            assign w_load  = w_ready && w_src_valid;

            // Valid bit and partial result; data only changes on a real load
            // so the tail result stays stable while stalled.
            always_ff @(posedge clk) begin
                if (reset) begin
                    r_valid <= 1'b0;
                    r_data  <= '0;
                end else if (w_ready) begin
                    r_valid <= w_src_valid;
                    if (w_src_valid) begin
                        r_data <= f_combine(w_src_a, w_src_b);
                    end
                end
            end

            // Unconsumed side operands ride along with the beat.
            if (SIDE_W > 0) begin : g_side
                logic [SIDE_W-1:0] r_side;
                logic [SIDE_W-1:0] w_side_src;

                if (gi == 0) begin : g_from_in
                    assign w_side_src = bus.in_b[SB_W-1:WIDTH];
                end else begin : g_from_prev
                    assign w_side_src = g_stage[gi-1].g_side.r_side[SIDE_W+WIDTH-1:WIDTH];
                end

                // Capture the remaining slices together with the partial result.
                always_ff @(posedge clk) begin
                    if (reset) begin
                        r_side <= '0;
                    end else if (w_load) begin
                        r_side <= w_side_src;
                    end
                end
            end

            assign w_valid[gi] = r_valid;
            assign w_data[gi]  = r_data;
        end
    endgenerate

    logic        w_deliver;
    logic [15:0] r_beat_count;

    assign w_deliver = w_valid[STAGES-1] && bus.out_ready;

    // Delivered-result counter, saturating at all ones.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_beat_count <= '0;
        end else if (w_deliver && (r_beat_count != 16'hFFFF)) begin
            r_beat_count <= r_beat_count + 16'd1;
        end
    end

    assign bus.in_ready   = g_stage[0].w_ready;
    assign bus.out_valid  = w_valid[STAGES-1];
    assign bus.out_data   = w_data[STAGES-1];
    assign bus.beat_count = r_beat_count;

endmodule

// File: doc/hier_pipe_chain.md
HIER_PIPE_CHAIN -- requirements
Module: hier_pipe_chain

Interface
REQ-001 SHALL have parameter WIDTH, default 2: operand and result width in bits, legal range 1..32.
REQ-002 SHALL have parameter STAGES, default 2: number of chained combine stages, legal range 1..16.
REQ-003 SHALL have parameter MODE, default 0: combine op, 0=XOR, 1=AND, 2=OR, 3=ADD modulo 2^WIDTH.
REQ-004 SHALL use one clock and a synchronous, active-high reset: port clk, input, 1 bit, all state updates on its rising edge.
REQ-005 SHALL have port reset, input, 1 bit, synchronous active-high reset.
REQ-006 SHALL have port in_valid, input, 1 bit, upstream beat present.
REQ-007 SHALL have port in_ready, output, 1 bit, block accepts a beat this cycle.
REQ-008 SHALL have port in_a, input, WIDTH bits, chain head operand.
REQ-009 SHALL have port in_b, input, STAGES*WIDTH bits, side operands; slice k = bits [k*WIDTH +: WIDTH] feeds stage k.
REQ-010 SHALL have port out_valid, output, 1 bit, result present.
REQ-011 SHALL have port out_ready, input, 1 bit, downstream accepts result.
REQ-012 SHALL have port out_data, output, WIDTH bits, chain result.
REQ-013 SHALL have port beat_count, output, 16 bits, number of results delivered, saturating.

Function
REQ-014 Stage 0 SHALL register r0 = in_a OP in_b[0] on acceptance; stage k>0 SHALL register rk = r(k-1) OP b[k] on advance.
REQ-015 Each stage SHALL carry a valid bit plus the unconsumed side operands b[k+1..STAGES-1] captured at acceptance.
REQ-016 Side operands SHALL NOT be sampled after the accepting cycle.
REQ-017 Handshake: a beat is accepted iff in_valid && in_ready, and delivered iff out_valid && out_ready.
REQ-018 Stage k SHALL advance (load from k-1) when it is empty or its content advances or is delivered in the same cycle (bubble collapse).
REQ-019 in_ready SHALL equal: stage 0 empty, or stage 0 advancing this cycle; combinational from valid bits and out_ready only.
REQ-020 out_valid SHALL equal the last-stage valid bit; out_data SHALL equal the last-stage result register.
REQ-021 Latency from acceptance to out_valid SHALL be exactly STAGES cycles with out_ready held high.
REQ-022 With out_ready held high, throughput SHALL be one beat per cycle, with no bubbles inserted.
REQ-023 While out_valid=1 and out_ready=0, out_data SHALL hold stable; upstream stages SHALL keep filling until all STAGES slots are full, then in_ready=0.
REQ-024 When the pipeline is full and out_ready rises, SHALL deliver and accept in the same cycle if in_valid=1.
REQ-025 MODE 3 SHALL discard the carry out of bit WIDTH-1.
REQ-026 beat_count SHALL increment by 1 per delivery and hold at 16'hFFFF; it SHALL NOT wrap.
REQ-027 in_valid with in_ready=0 SHALL have no effect on state.
REQ-028 Order SHALL be preserved: results leave in acceptance order, none lost or duplicated.

Reset
REQ-029 reset=1 at a clk edge SHALL clear all stage valid bits and beat_count to 0.
REQ-030 During and on the cycle after reset: out_valid=0 and in_ready=1; out_data SHALL be 0 (data registers cleared).
REQ-031 Reset mid-operation SHALL drop all in-flight beats; no delivery SHALL occur in the reset cycle.
REQ-032 Reset SHALL take priority over simultaneous accept or deliver.

Verification
REQ-033 XOR basic: WIDTH=2, STAGES=2, MODE=0, in_a=01, in_b={10,11}, out_ready=1 -> out_valid=1 two cycles later, out_data=00, beat_count=1.
REQ-034 ADD wrap: WIDTH=2, STAGES=2, MODE=3, in_a=11, in_b={01,11} -> out_data=11 (3+3=2 mod 4, 2+1=3).
REQ-035 Backpressure: STAGES=2, out_ready=0, 3 beats offered back-to-back -> 2 accepted, in_ready=0 on the 3rd; raise out_ready -> 3 results delivered in order, no loss or duplication.
REQ-036 Streaming: 8 consecutive beats with out_ready=1 -> 8 results on 8 consecutive cycles starting at cycle STAGES; beat_count=8.
REQ-037 Reset mid-flight: reset asserted with 2 beats in flight -> out_valid=0 the next cycle, beat_count=0, and the dropped beats never appear.
REQ-038 Saturation: deliver 65537 beats -> beat_count=16'hFFFF, which holds.
